// File: rtl/esl_dot_pe.sv
// -----------------------------------------------------------------------------
// esl_dot_pe -- frame-controlled multi-lane ESL processing element.
//
// N_LANES stochastic (x,y) pairs are weighted by LFSR-derived weight bitstreams
// and merged with an init pair by a round-robin (scaled) adder. A start/done
// FSM runs one frame of STREAM_LEN enabled cycles and counts output ones.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   enable            stall when low (RUN state frozen)
//   start             begin a frame (sampled in IDLE only)
//   abort             return to IDLE without a done pulse
//   mode              0 = unipolar (AND), 1 = bipolar (XNOR)
//   in_x, in_y        lane stochastic bits
//   init_x, init_y    init pair bits (slot sel == N_LANES)
//   weight            lane i weight = weight[i*BIN_LEN +: BIN_LEN], latched on start
//   out_x, out_y      registered adder output
//   busy              high while in RUN
//   done              one-cycle pulse at frame end
//   cnt_x, cnt_y      ones counted on out_x / out_y this frame
// -----------------------------------------------------------------------------
module esl_dot_pe #(
   parameter int                 BIN_LEN    = 8,
   parameter int                 N_LANES    = 4,
   parameter int                 STREAM_LEN = 255,
   parameter logic [BIN_LEN-1:0] LFSR_SEED  = 8'h01,
   parameter logic [BIN_LEN-1:0] LFSR_TAPS  = 8'hB8,
   parameter int                 CNT_W      = $clog2(STREAM_LEN + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       mode,
   input  logic [N_LANES-1:0]         in_x,
   input  logic [N_LANES-1:0]         in_y,
   input  logic                       init_x,
   input  logic                       init_y,
   input  logic [N_LANES*BIN_LEN-1:0] weight,
   output logic                       out_x,
   output logic                       out_y,
   output logic                       busy,
   output logic                       done,
   output logic [CNT_W-1:0]           cnt_x,
   output logic [CNT_W-1:0]           cnt_y
);

   localparam int SEL_W = $clog2(N_LANES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state;
   logic [BIN_LEN-1:0]         lfsr;
   logic [SEL_W-1:0]           sel;
   logic [CNT_W-1:0]           run_cnt;
   logic [N_LANES*BIN_LEN-1:0] weight_q;

   logic [N_LANES-1:0]         mx;
   logic                       sx;
   logic                       sy;

   // Per-lane weight bit: each lane compares against its own rotation of the
   // shared LFSR so the lanes see decorrelated random values.
   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      localparam int ROT = i % BIN_LEN;
      logic [BIN_LEN-1:0] r;
      logic               w;

      if (ROT == 0) begin : g_norot
         assign r = lfsr;
      end else begin : g_rot
         assign r = {lfsr[BIN_LEN-1-ROT:0], lfsr[BIN_LEN-1:BIN_LEN-ROT]};
      end

      assign w     = weight_q[i*BIN_LEN +: BIN_LEN] > r;
      assign mx[i] = mode ? ~(w ^ in_x[i]) : (w & in_x[i]);
   end

   // Round-robin scaled adder: one source per cycle, init pair in the last slot.
   always_comb begin
      // NOTE: defaults first so every path assigns sx/sy and no latch is inferred.
      sx = init_x;
      sy = init_y;
      for (int i = 0; i < N_LANES; i++) begin
         if (sel == SEL_W'(i)) begin
            sx = mx[i];
            sy = in_y[i];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state    <= IDLE;
         lfsr     <= LFSR_SEED;
         sel      <= '0;
         run_cnt  <= '0;
         weight_q <= '0;
         out_x    <= 1'b0;
         out_y    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt_x    <= '0;
         cnt_y    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  weight_q <= weight;
                  lfsr     <= LFSR_SEED;
                  sel      <= '0;
                  run_cnt  <= '0;
                  cnt_x    <= '0;
                  cnt_y    <= '0;
                  out_x    <= 1'b0;
                  out_y    <= 1'b0;
               end
            end

            RUN: begin
               // abort wins over frame end; counts keep their partial values
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (enable) begin
                  out_x   <= sx;
                  out_y   <= sy;
                  cnt_x   <= cnt_x + CNT_W'(sx);
                  cnt_y   <= cnt_y + CNT_W'(sy);
                  lfsr    <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
                  sel     <= (sel == SEL_W'(N_LANES)) ? '0 : sel + SEL_W'(1);
                  run_cnt <= run_cnt + CNT_W'(1);
                  if (run_cnt == CNT_W'(STREAM_LEN - 1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_esl_dot_pe.sv
// -----------------------------------------------------------------------------
// tb_esl_dot_pe -- self-checking bench for esl_dot_pe.
// A 4-lane instance covers constant-input frames, stall, abort, async reset
// and randomized frames; a 1-lane instance covers the single-lane LFSR case.
// -----------------------------------------------------------------------------
module tb_esl_dot_pe;

   localparam int         BIN_LEN    = 8;
   localparam int         N_LANES    = 4;
   localparam int         STREAM_LEN = 255;
   localparam int         CNT_W      = 8;
   localparam logic [7:0] SEED       = 8'h01;
   localparam logic [7:0] TAPS       = 8'hB8;

   logic        clock  = 1'b0;
   logic        reset  = 1'b1;
   logic        enable = 1'b0;
   logic        start  = 1'b0;
   logic        abort  = 1'b0;
   logic        mode   = 1'b0;
   logic [3:0]  in_x   = '0;
   logic [3:0]  in_y   = '0;
   logic        init_x = 1'b0;
   logic        init_y = 1'b0;
   logic [31:0] weight = '0;
   logic        out_x, out_y, busy, done;
   logic [7:0]  cnt_x, cnt_y;

   logic        start1   = 1'b0;
   logic [0:0]  in_x1    = '0;
   logic [0:0]  in_y1    = '0;
   logic        init_x1  = 1'b0;
   logic        init_y1  = 1'b0;
   logic [7:0]  weight1  = '0;
   logic        out_x1, out_y1, busy1, done1;
   logic [7:0]  cnt_x1, cnt_y1;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  lfsr_seq [0:STREAM_LEN];

   typedef struct {
      logic       md;
      logic [3:0] ix;
      logic [3:0] iy;
      logic       i0x;
      logic       i0y;
      int         ex;
      int         ey;
   } vec_t;

   vec_t vecs [5];

   esl_dot_pe u_dut (
      .clock(clock), .reset(reset), .enable(enable), .start(start), .abort(abort),
      .mode(mode), .in_x(in_x), .in_y(in_y), .init_x(init_x), .init_y(init_y),
      .weight(weight), .out_x(out_x), .out_y(out_y), .busy(busy), .done(done),
      .cnt_x(cnt_x), .cnt_y(cnt_y)
   );

   esl_dot_pe #(.N_LANES(1)) u_dut1 (
      .clock(clock), .reset(reset), .enable(enable), .start(start1), .abort(abort),
      .mode(mode), .in_x(in_x1), .in_y(in_y1), .init_x(init_x1), .init_y(init_y1),
      .weight(weight1), .out_x(out_x1), .out_y(out_y1), .busy(busy1), .done(done1),
      .cnt_x(cnt_x1), .cnt_y(cnt_y1)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference slot value {sx, sy} for enabled step k of a frame, computed
   // directly from the step number: LFSR state from the precomputed sequence,
   // round-robin slot from k mod (n+1), rotation by plain arithmetic.
   function automatic logic [1:0] ref_slot(input int k, input int n, input logic md,
                                           input logic [31:0] wts, input logic [3:0] ix,
                                           input logic [3:0] iy, input logic ix0,
                                           input logic iy0);
      int   slot, rot, v, r, w;
      logic sxv;
      slot = k % (n + 1);
      if (slot == n) return {ix0, iy0};
      rot = slot % BIN_LEN;
      v   = int'(lfsr_seq[k]);
      r   = ((v << rot) | (v >> (BIN_LEN - rot))) & 255;
      w   = (int'(wts[slot*8 +: 8]) > r) ? 1 : 0;
      if (md) sxv = (w == int'(ix[slot]));
      else    sxv = (w == 1) && ix[slot];
      return {sxv, iy[slot]};
   endfunction

   // Full frame with constant inputs; checks busy length, done pulse and counts.
   task automatic run_const(input vec_t v, input int idx);
      int n, guard;
      mode = v.md; in_x = v.ix; in_y = v.iy; init_x = v.i0x; init_y = v.i0y;
      weight = '0; enable = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; guard = 0;
      while (!done && guard < 600) begin
         if (busy) n++;
         tick();
         guard++;
      end
      check($sformatf("vec%0d_done", idx), 64'(done), 64'd1);
      check($sformatf("vec%0d_busy_len", idx), 64'(n), 64'(STREAM_LEN));
      check($sformatf("vec%0d_cnt_x", idx), 64'(cnt_x), 64'(v.ex));
      check($sformatf("vec%0d_cnt_y", idx), 64'(cnt_y), 64'(v.ey));
      tick();
      check($sformatf("vec%0d_done_pulse", idx), 64'(done), 64'd0);
      check($sformatf("vec%0d_cnt_hold", idx), 64'({cnt_x, cnt_y}), 64'({8'(v.ex), 8'(v.ey)}));
   endtask

   initial begin
      int         n, guard, k, ecx, ecy, ex1, ey1;
      logic [7:0] held;
      logic       eox, eoy;
      logic [1:0] s;
      logic       done_seen;

      lfsr_seq[0] = SEED;
      for (int t = 0; t < STREAM_LEN; t++)
         lfsr_seq[t+1] = (lfsr_seq[t] >> 1) ^ (lfsr_seq[t][0] ? TAPS : 8'h00);

      // Each of the 5 slots gets 51 of the 255 cycles.
      vecs[0] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 51,  255};
      vecs[1] = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 255, 255};
      vecs[2] = '{1'b1, 4'h5, 4'h3, 1'b0, 1'b0, 102, 102};
      vecs[3] = '{1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 0,   51};
      vecs[4] = '{1'b1, 4'hA, 4'h8, 1'b1, 1'b0, 153, 51};

      // Reset values
      tick(); tick();
      check("rst_outs", 64'({out_x, out_y, busy, done}), 64'd0);
      check("rst_cnts", 64'({cnt_x, cnt_y}), 64'd0);
      reset = 1'b0;
      tick();

      // Constant-input frames
      for (int i = 0; i < 5; i++) run_const(vecs[i], i);

      // Stall for 10 cycles mid-frame, plus start pulses during RUN
      mode = 1'b0; in_x = 4'hF; in_y = 4'hF; init_x = 1'b1; init_y = 1'b1;
      weight = '0; enable = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; guard = 0; held = '0;
      while (!done && guard < 600) begin
         if (busy) n++;
         if (guard == 100) held = cnt_y;
         if (guard == 110) check("stall_hold", 64'(cnt_y), 64'(held));
         enable = !(guard >= 100 && guard < 110);
         start  = (guard >= 50 && guard < 53);
         tick();
         guard++;
      end
      enable = 1'b1; start = 1'b0;
      check("stall_cnt100", 64'(held), 64'd100);
      check("stall_busy_len", 64'(n), 64'(STREAM_LEN + 10));
      check("stall_cnts", 64'({cnt_x, cnt_y}), 64'({8'd51, 8'd255}));
      tick();

      // Abort after 100 enabled cycles
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (100) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", 64'({busy, done}), 64'd0);
      check("abort_cnts", 64'({cnt_x, cnt_y}), 64'({8'd20, 8'd100}));
      done_seen = 1'b0;
      repeat (5) begin
         tick();
         if (done || busy) done_seen = 1'b1;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);
      check("abort_cnt_held", 64'(cnt_y), 64'd100);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_clear", 64'({busy, cnt_x, cnt_y}), 64'({1'b1, 16'd0}));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("restart_abort", 64'(busy), 64'd0);

      // Asynchronous reset between edges while running
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      #2 reset = 1'b1;
      #1;
      check("areset_outs", 64'({out_x, out_y, busy, done}), 64'd0);
      check("areset_cnts", 64'({cnt_x, cnt_y}), 64'd0);
      check("areset_lfsr", 64'(u_dut.lfsr), 64'(SEED));
      #2 reset = 1'b0;
      tick();
      tick();
      check("areset_idle", 64'({busy, done}), 64'd0);

      // Single-lane instance: lane weight 0xFF against its LFSR
      mode = 1'b0; weight1 = 8'hFF; in_x1 = 1'b1; in_y1 = 1'b1;
      init_x1 = 1'b0; init_y1 = 1'b0; enable = 1'b1;
      ex1 = 0; ey1 = 0;
      for (int t = 0; t < STREAM_LEN; t++) begin
         s = ref_slot(t, 1, 1'b0, 32'(weight1), 4'(in_x1), 4'(in_y1), 1'b0, 1'b0);
         ex1 += int'(s[1]);
         ey1 += int'(s[0]);
      end
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      guard = 0;
      while (!done1 && guard < 600) begin
         tick();
         guard++;
      end
      check("lane1_done", 64'(done1), 64'd1);
      check("lane1_cnt_x", 64'(cnt_x1), 64'(ex1));
      check("lane1_cnt_y", 64'(cnt_y1), 64'(ey1));
      tick();

      // Randomized frames against the reference model
      for (int f = 0; f < 4; f++) begin
         weight = $urandom;
         mode   = 1'($urandom);
         enable = 1'b1;
         start  = 1'b1;
         tick();
         start = 1'b0;
         check($sformatf("rand%0d_start", f), 64'({out_x, out_y, busy, done, cnt_x, cnt_y}),
               64'({4'b0010, 16'd0}));
         k = 0; ecx = 0; ecy = 0; eox = 1'b0; eoy = 1'b0; guard = 0;
         while (k < STREAM_LEN && guard < 2000) begin
            in_x   = 4'($urandom);
            in_y   = 4'($urandom);
            init_x = 1'($urandom);
            init_y = 1'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            start  = ($urandom_range(0, 15) == 0);
            if (enable) begin
               {eox, eoy} = ref_slot(k, N_LANES, mode, weight, in_x, in_y, init_x, init_y);
               ecx += int'(eox);
               ecy += int'(eoy);
               k++;
            end
            tick();
            guard++;
            check($sformatf("rand%0d_k%0d", f, k),
                  64'({out_x, out_y, busy, done, cnt_x, cnt_y}),
                  64'({eox, eoy, (k < STREAM_LEN), (k == STREAM_LEN), 8'(ecx), 8'(ecy)}));
         end
         check($sformatf("rand%0d_steps", f), 64'(k), 64'(STREAM_LEN));
         start = 1'b0; enable = 1'b1;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
